// File: rtl/line_sender_pkg.sv
// Shared line-protocol definitions for the line sender and the line receiver:
// byte-count helpers, the packet header value and the sender FSM encoding.
package line_sender_pkg;

    // Bytes needed to carry a field of the given bit width.
    function automatic int bytes_for(input int bits);
        return (bits + 7) / 8;
    endfunction

    localparam logic [7:0] HEADER_BYTE = 8'hA5;

    // Byte counts at the default 10-machine / 9-bit-joltage geometry.
    localparam int BPB = bytes_for(10);
    localparam int BPJ = bytes_for(9);

    typedef enum logic [2:0] {
        IDLE,
        SEND_HEADER,
        SEND_COUNT,
        SEND_BUTTONS,
        SEND_JOLTAGES
    } line_state_t;

endpackage

// File: rtl/line_sender_uart_tx.sv
// 8N1 UART bit serializer: start bit, 8 data bits LSB first, one stop bit,
// each held for CLKS_PER_BIT cycles. tx_done pulses the cycle after the
// stop bit ends.
module uart_tx #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_byte,
    output logic       uart_output,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] LAST_CLK = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    logic [9:0]    frame;
    logic          active;

    // Load a frame on start, then shift one bit out every CLKS_PER_BIT cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            active  <= 1'b0;
            tx_done <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            frame   <= '1;
        end else begin
            tx_done <= 1'b0;
            if (!active) begin
                if (tx_start) begin
                    frame   <= {1'b1, tx_byte, 1'b0};
                    active  <= 1'b1;
                    clk_cnt <= '0;
                    bit_idx <= '0;
                end
            end else if (clk_cnt == LAST_CLK) begin
                clk_cnt <= '0;
                if (bit_idx == 4'd9) begin
                    active  <= 1'b0;
                    tx_done <= 1'b1;
                end else begin
                    bit_idx <= bit_idx + 4'd1;
                    frame   <= {1'b1, frame[9:1]};
                end
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
        end
    end

    // Line idles high; abandoning a frame on reset releases it immediately.
    assign uart_output = active ? frame[0] : 1'b1;
    assign tx_busy     = active;

endmodule

// File: rtl/line_sender.sv
// Captures one button/joltage snapshot on send and streams it as a packet:
// header, clamped count, button mask bytes, joltage bytes (all LSB first).
module line_sender
    import line_sender_pkg::*;
#(
    parameter int CLKS_PER_BIT     = 10416,
    parameter int MACHINE_COUNT    = 10,
    parameter int MAX_BUTTON_COUNT = 13,
    parameter int BITS_PER_JOLTAGE = 9
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        send,
    input  logic [$clog2(MAX_BUTTON_COUNT+1)-1:0]       button_count,
    input  logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0]   flattened_buttons,
    input  logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0]   flattened_machines,
    output logic                                        uart_output,
    output logic                                        busy,
    output logic                                        line_sent
);
    localparam int CW         = $clog2(MAX_BUTTON_COUNT + 1);
    localparam int MB         = bytes_for(MACHINE_COUNT);
    localparam int JB         = bytes_for(BITS_PER_JOLTAGE);
    localparam int BTN_BYTES  = MAX_BUTTON_COUNT * MB;
    localparam int JOLT_BYTES = MACHINE_COUNT * JB;
    localparam int BSW        = $clog2(BTN_BYTES);
    localparam int JSW        = $clog2(JOLT_BYTES);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BUTTON_COUNT);

    line_state_t state, state_next;

    logic [MACHINE_COUNT*MAX_BUTTON_COUNT-1:0] cap_buttons;
    logic [MACHINE_COUNT*BITS_PER_JOLTAGE-1:0] cap_machines;
    logic [CW-1:0]                             cap_count;
    logic [7:0]                                item_idx, byte_idx;
    logic                                      item_wrap, last_item, packet_end;
    logic                                      tx_start, tx_busy, tx_done;
    logic [7:0]                                tx_byte;
    logic [BTN_BYTES-1:0][7:0]                 btn_flat;
    logic [JOLT_BYTES-1:0][7:0]                jolt_flat;
    logic [BSW-1:0]                            btn_sel;
    logic [JSW-1:0]                            jolt_sel;

    // Zero-pad every captured field to whole bytes, laid out in send order.
    for (genvar i = 0; i < MAX_BUTTON_COUNT; i++) begin : g_btn
        logic [MB*8-1:0] pad;
        assign pad = (MB*8)'(cap_buttons[i*MACHINE_COUNT +: MACHINE_COUNT]);
        for (genvar j = 0; j < MB; j++) begin : g_byte
            assign btn_flat[i*MB+j] = pad[j*8 +: 8];
        end
    end
    for (genvar k = 0; k < MACHINE_COUNT; k++) begin : g_jolt
        logic [JB*8-1:0] pad;
        assign pad = (JB*8)'(cap_machines[k*BITS_PER_JOLTAGE +: BITS_PER_JOLTAGE]);
        for (genvar j = 0; j < JB; j++) begin : g_byte
            assign jolt_flat[k*JB+j] = pad[j*8 +: 8];
        end
    end

    assign btn_sel  = BSW'(int'(item_idx) * MB + int'(byte_idx));
    assign jolt_sel = JSW'(int'(item_idx) * JB + int'(byte_idx));

    // Section bookkeeping: end of the current item and of the current section.
    always_comb begin
        item_wrap = 1'b0;
        last_item = 1'b0;
        if (state == SEND_BUTTONS) begin
            item_wrap = (byte_idx == 8'(MB - 1));
            last_item = (item_idx == 8'(cap_count) - 8'd1);
        end else if (state == SEND_JOLTAGES) begin
            item_wrap = (byte_idx == 8'(JB - 1));
            last_item = (item_idx == 8'(MACHINE_COUNT - 1));
        end
    end
    assign packet_end = (state == SEND_JOLTAGES) && tx_done && item_wrap && last_item;

    // FSM state register; reset overrides a simultaneous send.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state: each sending state advances on the serializer's byte-done.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:          if (send) state_next = SEND_HEADER;
            SEND_HEADER:   if (tx_done) state_next = SEND_COUNT;
            SEND_COUNT:    if (tx_done) state_next = (cap_count == '0) ? SEND_JOLTAGES : SEND_BUTTONS;
            SEND_BUTTONS:  if (tx_done && item_wrap && last_item) state_next = SEND_JOLTAGES;
            SEND_JOLTAGES: if (packet_end) state_next = IDLE;
            default:       state_next = IDLE;
        endcase
    end

    // Outputs: byte for the current position; start whenever the serializer is free.
    always_comb begin
        tx_byte = 8'h00;
        case (state)
            SEND_HEADER:   tx_byte = HEADER_BYTE;
            SEND_COUNT:    tx_byte = 8'(cap_count);
            SEND_BUTTONS:  tx_byte = btn_flat[btn_sel];
            SEND_JOLTAGES: tx_byte = jolt_flat[jolt_sel];
            default:       tx_byte = 8'h00;
        endcase
        tx_start = (state != IDLE) && !tx_busy && !tx_done;
    end

    // Snapshot capture, (item, byte) counters and the end-of-packet pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            item_idx     <= '0;
            byte_idx     <= '0;
            line_sent    <= 1'b0;
            cap_count    <= '0;
            cap_buttons  <= '0;
            cap_machines <= '0;
        end else begin
            line_sent <= packet_end;
            if (state == IDLE) begin
                item_idx <= '0;
                byte_idx <= '0;
                if (send) begin
                    cap_count    <= (button_count > MAX_CNT) ? MAX_CNT : button_count;
                    cap_buttons  <= flattened_buttons;
                    cap_machines <= flattened_machines;
                end
            end else if (tx_done && (state == SEND_BUTTONS || state == SEND_JOLTAGES)) begin
                if (item_wrap) begin
                    byte_idx <= '0;
                    item_idx <= last_item ? 8'd0 : item_idx + 8'd1;
                end else begin
                    byte_idx <= byte_idx + 8'd1;
                end
            end
        end
    end

    assign busy = (state != IDLE);

    uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
        .clk         (clk),
        .reset       (reset),
        .tx_start    (tx_start),
        .tx_byte     (tx_byte),
        .uart_output (uart_output),
        .tx_busy     (tx_busy),
        .tx_done     (tx_done)
    );

endmodule

// File: tb/tb_line_sender.sv
// Bench for line_sender: a serial monitor decodes every frame off the line,
// checks bit widths and gaps, and scores each byte against a packet model.
module tb_line_sender;
    localparam int CPB = 4;
    localparam int MC  = 10;
    localparam int MBC = 13;
    localparam int BJ  = 9;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          send = 1'b0;
    logic [3:0]    button_count = '0;
    logic [MC*MBC-1:0] flattened_buttons = '0;
    logic [MC*BJ-1:0]  flattened_machines = '0;
    logic          uart_output, busy, line_sent;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int send_cyc = 0;
    int last_end_cyc = 0;
    int sent_pulses = 0;
    bit first_byte = 1'b1;
    bit mon_en = 1'b1;
    bit prev_busy = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    line_sender #(
        .CLKS_PER_BIT(CPB), .MACHINE_COUNT(MC),
        .MAX_BUTTON_COUNT(MBC), .BITS_PER_JOLTAGE(BJ)
    ) dut (
        .clk(clk), .reset(reset), .send(send),
        .button_count(button_count),
        .flattened_buttons(flattened_buttons),
        .flattened_machines(flattened_machines),
        .uart_output(uart_output), .busy(busy), .line_sent(line_sent)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_max(input string name, input int act, input int lim);
        tests++;
        if (act > lim) begin
            fails++;
            $display("FAIL %s: got %0d, required <= %0d", name, act, lim);
        end
    endtask

    // Packet model: byte list straight from the protocol rules.
    task automatic model_packet(input int bc, input logic [MC*MBC-1:0] b, input logic [MC*BJ-1:0] m);
        int n;
        logic [15:0] v;
        n = (bc > MBC) ? MBC : bc;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            v = 16'(b >> (i * MC)) & 16'h03FF;
            exp_q.push_back(v[7:0]);
            exp_q.push_back(v[15:8]);
        end
        for (int k = 0; k < MC; k++) begin
            v = 16'(m >> (k * BJ)) & 16'h01FF;
            exp_q.push_back(v[7:0]);
            exp_q.push_back(v[15:8]);
        end
    endtask

    // Line monitor: decode frames, check 4-cycle bits, framing, gaps and bytes.
    initial begin : monitor
        logic [9:0] bits;
        bit bad;
        int st;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && uart_output === 1'b0) begin
                st = cyc;
                bad = 1'b0;
                if (first_byte) check_max("start_latency", st - send_cyc, 2);
                else            check_max("interbyte_gap", st - last_end_cyc - 1, 2);
                first_byte = 1'b0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c < CPB; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (c == 0) bits[b] = uart_output;
                        else if (uart_output !== bits[b]) bad = 1'b1;
                    end
                end
                last_end_cyc = cyc;
                check("framing", {29'd0, bad, bits[0], bits[9]}, 32'd1);
                rx_q.push_back(bits[8:1]);
                if (exp_q.size() > 0) check("byte", bits[8:1], exp_q.pop_front());
                else check("unexpected_byte_queue_size", exp_q.size(), 1);
            end
        end
    end

    // line_sent must coincide with busy falling.
    initial begin : pulse_mon
        forever begin
            @(negedge clk);
            if (line_sent === 1'b1) begin
                sent_pulses++;
                check("line_sent_at_busy_fall", {30'd0, prev_busy, busy}, 32'd2);
            end
            prev_busy = busy;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_packet(input logic [3:0] bc, input logic [MC*MBC-1:0] b, input logic [MC*BJ-1:0] m);
        button_count = bc;
        flattened_buttons = b;
        flattened_machines = m;
        model_packet(int'(bc), b, m);
        rx_q.delete();
        first_byte = 1'b1;
        send_cyc = cyc;
        send = 1'b1;
        tick();
        send = 1'b0;
    endtask

    task automatic wait_sent(input string name, input int nbytes);
        int p0;
        int n;
        p0 = sent_pulses;
        n = 0;
        while (sent_pulses == p0 && n < 3000) begin
            tick();
            n++;
        end
        check({name, "_line_sent_once"}, sent_pulses - p0, 1);
        check({name, "_byte_total"}, rx_q.size(), nbytes);
        check({name, "_model_drained"}, exp_q.size(), 0);
    endtask

    logic [MC*MBC-1:0] b;
    logic [MC*BJ-1:0]  m;
    logic [MC*BJ-1:0]  m09;
    logic [MC*MBC-1:0] b3;

    initial begin : stim
        #(900_000);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset, including a send that coincides with reset.
        repeat (3) tick();
        check("reset_uart_high", uart_output, 1);
        check("reset_busy_low", busy, 0);
        check("reset_line_sent_low", line_sent, 0);
        send = 1'b1;
        tick();
        send = 1'b0;
        reset = 1'b0;
        tick();
        check("send_during_reset_ignored", busy, 0);
        repeat (3) tick();
        check("idle_line_high", uart_output, 1);

        // Two masks with recognisable bytes.
        b = '0; b[9:0] = 10'h2A5; b[19:10] = 10'h15A;
        m = '0; m[8:0] = 9'h1FF;
        for (int k = 1; k < MC; k++) m[k*BJ +: BJ] = 9'(k * 50);
        start_packet(4'd2, b, m);
        check("busy_after_accept", busy, 1);
        wait_sent("n2", 26);
        check("n2_b0", rx_q[0], 8'hA5);
        check("n2_b1", rx_q[1], 8'h02);
        check("n2_b2", rx_q[2], 8'hA5);
        check("n2_b3", rx_q[3], 8'h02);
        check("n2_b4", rx_q[4], 8'h5A);
        check("n2_b5", rx_q[5], 8'h01);
        check("n2_j0_lo", rx_q[6], 8'hFF);
        check("n2_j0_hi", rx_q[7], 8'h01);
        check("busy_low_after_packet", busy, 0);

        // Three masks at the edges of the mask width, joltages 0..9.
        b3 = '0; b3[9:0] = 10'h3FF; b3[19:10] = 10'h001; b3[29:20] = 10'h200;
        m09 = '0;
        for (int k = 0; k < MC; k++) m09[k*BJ +: BJ] = 9'(k);
        tick();
        start_packet(4'd3, b3, m09);
        wait_sent("n3", 28);
        check("n3_count", rx_q[1], 8'h03);
        check("n3_mask0_lo", rx_q[2], 8'hFF);
        check("n3_mask0_hi", rx_q[3], 8'h03);
        check("n3_mask2_hi", rx_q[7], 8'h02);
        check("n3_j9_lo", rx_q[26], 8'h09);

        // No buttons: count byte then joltages directly.
        tick();
        start_packet(4'd0, b3, m09);
        wait_sent("n0", 22);
        check("n0_count", rx_q[1], 8'h00);
        check("n0_j0_lo", rx_q[2], 8'h00);
        check("n0_j1_lo", rx_q[4], 8'h01);

        // Over-range count clamps to 13; next send right after line_sent.
        b = '0;
        for (int i = 0; i < MBC; i++) b[i*MC +: MC] = 10'(i * 77 + 1);
        tick();
        start_packet(4'd15, b, m);
        wait_sent("clamp", 48);
        check("clamp_count", rx_q[1], 8'h0D);
        start_packet(4'd3, b3, m09);
        wait_sent("back2back", 28);

        // Send and input changes while busy must not disturb the packet.
        tick();
        start_packet(4'd3, b3, m09);
        repeat (300) tick();
        button_count = 4'd1;
        flattened_buttons = '1;
        flattened_machines = '1;
        send = 1'b1;
        tick();
        send = 1'b0;
        wait_sent("ignore_send", 28);
        repeat (100) tick();
        check("no_second_packet_busy", busy, 0);
        check("no_second_packet_line", uart_output, 1);

        // Reset in the middle of a data bit abandons the frame at once.
        mon_en = 1'b0;
        send = 1'b1;
        tick();
        send = 1'b0;
        repeat (20) tick();
        check("pre_reset_busy", busy, 1);
        reset = 1'b1;
        tick();
        check("mid_reset_uart_high", uart_output, 1);
        check("mid_reset_busy_low", busy, 0);
        reset = 1'b0;
        tick();
        check("post_reset_idle_high", uart_output, 1);
        mon_en = 1'b1;
        start_packet(4'd3, b3, m09);
        wait_sent("after_reset", 28);

        repeat (5) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/line_sender.md
LINE_SENDER -- requirements
Module: line_sender

Interface
REQ-001 Parameter CLKS_PER_BIT, default 10416, clock cycles per UART bit.
REQ-002 Parameter MACHINE_COUNT, default 10, bits per button mask and number of joltage fields.
REQ-003 Parameter MAX_BUTTON_COUNT, default 13, button mask slots.
REQ-004 Parameter BITS_PER_JOLTAGE, default 9, width of each joltage field.
REQ-005 Port clk  input  1  sole clock; all logic on rising edge.
REQ-006 Port reset  input  1  synchronous, active-high reset.
REQ-007 Port send  input  1  one-cycle request to transmit one line packet.
REQ-008 Port button_count  input  clog2(MAX_BUTTON_COUNT+1)  number of valid button masks.
REQ-009 Port flattened_buttons  input  MACHINE_COUNT*MAX_BUTTON_COUNT  mask i at [i*MACHINE_COUNT +: MACHINE_COUNT].
REQ-010 Port flattened_machines  input  MACHINE_COUNT*BITS_PER_JOLTAGE  joltage k at [k*BITS_PER_JOLTAGE +: BITS_PER_JOLTAGE].
REQ-011 Port uart_output  output  1  serial line, idle high.
REQ-012 Port busy  output  1  high from the cycle after an accepted send until the final stop bit ends.
REQ-013 Port line_sent  output  1  one-cycle pulse in the cycle busy falls.

Function
REQ-014 Packet byte order SHALL be: header 0xA5; count byte; button bytes; joltage bytes.
REQ-015 Count byte SHALL equal min(button_count, MAX_BUTTON_COUNT), zero-extended to 8 bits; this clamped value is the effective count N.
REQ-016 Button section SHALL send masks 0..N-1, each as BPB=ceil(MACHINE_COUNT/8) bytes, least significant byte first, unused upper bits zero.
REQ-017 Joltage section SHALL send all MACHINE_COUNT fields, index 0 first, each as BPJ=ceil(BITS_PER_JOLTAGE/8) bytes, LSB first, zero-padded.
REQ-018 N=0 SHALL skip the button section; the count byte is followed directly by joltage byte 0.
REQ-019 send SHALL be accepted only in IDLE; send while busy SHALL be ignored with no effect on the packet in flight.
REQ-020 On acceptance all data inputs SHALL be captured in one cycle; later input changes SHALL not affect the packet.
REQ-021 FSM states: IDLE, SEND_HEADER, SEND_COUNT, SEND_BUTTONS, SEND_JOLTAGES; each state advances on byte-done from the serializer; SEND_JOLTAGES after the last byte returns to IDLE.
REQ-022 Byte indices SHALL be (item index, byte-within-item) counter pairs; item index advances on byte-within-item wrap.
REQ-023 UART framing: start bit 0, 8 data bits LSB first, one stop bit 1, each exactly CLKS_PER_BIT cycles.
REQ-024 Start bit of the first byte SHALL begin no later than 2 cycles after send; successive bytes SHALL have at most 2 idle cycles between a stop bit end and the next start bit.
REQ-025 Total bytes per packet SHALL be 2 + N*BPB + MACHINE_COUNT*BPJ (48 at default parameters with N=13).

Reset
REQ-026 On reset: FSM to IDLE, uart_output 1, busy 0, line_sent 0, serializer idle; a frame in progress SHALL be abandoned immediately with the line driven high the next cycle.
REQ-027 send asserted in the same cycle as reset SHALL be ignored.

Structure
REQ-028 Byte-count localparams (BPB, BPJ), header value 0xA5 and FSM state encodings SHALL live in the shared line-protocol package, used by both this block and the line receiver.
REQ-029 One sub-module, uart_tx (ports clk, reset, tx_start, tx_byte[7:0], uart_output, tx_busy, tx_done pulse), SHALL hold the bit serializer; line_sender holds the FSM and capture registers.

Verification
REQ-030 Loopback: default params, N=3, masks 0x3FF/0x001/0x200, joltages 0..9 into the line receiver -> received masks, count 3 and joltages match exactly; line_sent pulses once.
REQ-031 Byte capture: CLKS_PER_BIT=4, N=2, mask0=0x2A5, mask1=0x15A -> bytes A5,02,A5,02,5A,01, then 20 joltage bytes; each bit 4 cycles wide.
REQ-032 N=0 and button_count=15 (clamped to 13) -> 22 and 48 bytes respectively; count bytes 0x00 and 0x0D.
REQ-033 send pulsed mid-packet and inputs changed after acceptance -> packet unchanged, exactly one line_sent.
REQ-034 reset asserted mid data bit -> uart_output high next cycle, busy 0; new send afterwards yields a clean full packet.
REQ-035 send on the cycle after line_sent -> accepted; second packet starts within 2 cycles, no framing error.
